// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: signal bundle between the two requesters, the arbiter and
// the DDR3 memory block's mux-side command port (ui_clk domain).
//
// Modports:
//   slave  - the arbiter's view: takes requests and memory responses, drives
//            acks, read returns, memory command strobes and status.
//   master - the environment's view: requesters plus the memory block.
//
// Signal groups:
//   requester 0/1 : reqN, weN, addrN, widthN, wdataN  -> arbiter
//                   ackN, rdataN, rvalidN             <- arbiter
//   memory        : mem_rd, mem_wr, mem_addr, mem_data_width, mem_wr_data -> memory
//                   mem_rd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid <- memory
//   status        : busy, owner, err_stray, err_timeout

interface mem_arbiter_if #(
  parameter int ADDR_W = 27
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [1:0]        width0;
  logic [1:0]        width1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  logic              ack0;
  logic              ack1;
  logic [31:0]       rdata0;
  logic [31:0]       rdata1;
  logic              rvalid0;
  logic              rvalid1;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_data_width;
  logic [31:0]       mem_wr_data;
  logic              mem_rd_ready;
  logic              mem_wr_ready;
  logic [31:0]       mem_rd_data;
  logic              mem_rd_valid;

  logic              busy;
  logic              owner;
  logic              err_stray;
  logic              err_timeout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, width0, width1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1, rvalid0, rvalid1,
    output mem_rd, mem_wr, mem_addr, mem_data_width, mem_wr_data,
    input  mem_rd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid,
    output busy, owner, err_stray, err_timeout
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, width0, width1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1, rvalid0, rvalid1,
    input  mem_rd, mem_wr, mem_addr, mem_data_width, mem_wr_data,
    output mem_rd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid,
    input  busy, owner, err_stray, err_timeout
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter/sequencer in front of the DDR3 memory
// block's mux-side command port, clocked by ui_clk.
//
// Port 0 (GBA cartridge bus) has fixed priority; port 1 (host loader/debug)
// is protected from starvation: after STARVE_LIMIT consecutive port-0 grants
// made while port 1 waits, port 1 wins the next arbitration.
// One command is in flight at a time. The command registers (address, width,
// write data) stay stable through the read return because the memory block
// decodes read data combinationally from mem_addr/mem_data_width.
//
// Ports:
//   clk  - ui_clk
//   rst  - synchronous active-high reset (rst_ui_sync)
//   bus  - mem_arbiter_if.slave: requester handshakes, memory command port,
//          status (busy, owner, err_stray, err_timeout)
//
// Optional build macro MEM_ARB_RD_TIMEOUT_EN: adds a read-return watchdog.
// After TIMEOUT_CYCLES cycles in WAIT_RD without mem_rd_valid the owner gets
// 32'hDEADBEEF with an rvalid pulse and err_timeout is set sticky. Without the
// macro WAIT_RD waits indefinitely and err_timeout is tied low.

module mem_arbiter #(
  parameter int ADDR_W         = 27,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_t            state;
  logic [CNT_W-1:0]  starve_cnt;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        width_r;
  logic [31:0]       wdata_r;
  logic              owner_r;
  logic              mem_rd_r;
  logic              mem_wr_r;
  logic              busy_r;
  logic              rvalid0_r;
  logic              rvalid1_r;
  logic [31:0]       rdata0_r;
  logic [31:0]       rdata1_r;
  logic              err_stray_r;

  // Arbitration decision for the current IDLE cycle.
  logic              grant;
  logic              pick1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_width;
  logic [31:0]       sel_wdata;
  logic              accept;

  always_comb begin
    grant     = bus.req0 | bus.req1;
    // Port 1 wins when starved or when port 0 is not asking.
    pick1     = bus.req1 & ((starve_cnt == CNT_MAX) | ~bus.req0);
    sel_we    = pick1 ? bus.we1    : bus.we0;
    sel_addr  = pick1 ? bus.addr1  : bus.addr0;
    sel_width = pick1 ? bus.width1 : bus.width0;
    sel_wdata = pick1 ? bus.wdata1 : bus.wdata0;
  end

  // Strobes are only ever high in ISSUE, so no state qualifier is needed.
  assign accept = (mem_rd_r & bus.mem_rd_ready) | (mem_wr_r & bus.mem_wr_ready);

`ifdef MEM_ARB_RD_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            err_timeout_r;
`else
  // The parameter stays in both builds so instantiations need not change;
  // nothing is built from it here.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      width_r     <= '0;
      wdata_r     <= '0;
      owner_r     <= 1'b0;
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      busy_r      <= 1'b0;
      rvalid0_r   <= 1'b0;
      rvalid1_r   <= 1'b0;
      rdata0_r    <= '0;
      rdata1_r    <= '0;
      err_stray_r <= 1'b0;
`ifdef MEM_ARB_RD_TIMEOUT_EN
      to_cnt        <= '0;
      err_timeout_r <= 1'b0;
`endif
    end else begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;

      if (bus.mem_rd_valid && state != WAIT_RD) begin
        err_stray_r <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!bus.req1) begin
            starve_cnt <= '0;
          end
          if (grant) begin
            owner_r  <= pick1;
            we_r     <= sel_we;
            addr_r   <= sel_addr;
            width_r  <= sel_width;
            wdata_r  <= sel_wdata;
            mem_rd_r <= ~sel_we;
            mem_wr_r <= sel_we;
            busy_r   <= 1'b1;
            state    <= ISSUE;
            if (pick1) begin
              starve_cnt <= '0;
            end else if (bus.req1) begin
              starve_cnt <= sat_inc(starve_cnt);
            end
          end
        end

        ISSUE: begin
          if (accept) begin
            mem_rd_r <= 1'b0;
            mem_wr_r <= 1'b0;
            if (we_r) begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end else begin
              state  <= WAIT_RD;
`ifdef MEM_ARB_RD_TIMEOUT_EN
              to_cnt <= '0;
`endif
            end
          end
        end

        WAIT_RD: begin
          if (bus.mem_rd_valid) begin
            if (owner_r) begin
              rdata1_r  <= bus.mem_rd_data;
              rvalid1_r <= 1'b1;
            end else begin
              rdata0_r  <= bus.mem_rd_data;
              rvalid0_r <= 1'b1;
            end
            state  <= IDLE;
            busy_r <= 1'b0;
          end
`ifdef MEM_ARB_RD_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            // Memory never answered: hand back a marker word so the
            // requester is not left hanging.
            if (owner_r) begin
              rdata1_r  <= 32'hDEADBEEF;
              rvalid1_r <= 1'b1;
            end else begin
              rdata0_r  <= 32'hDEADBEEF;
              rvalid0_r <= 1'b1;
            end
            err_timeout_r <= 1'b1;
            state         <= IDLE;
            busy_r        <= 1'b0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Ack is combinational so the requester sees it in the acceptance cycle.
  assign bus.ack0           = accept & ~owner_r;
  assign bus.ack1           = accept & owner_r;
  assign bus.rdata0         = rdata0_r;
  assign bus.rdata1         = rdata1_r;
  assign bus.rvalid0        = rvalid0_r;
  assign bus.rvalid1        = rvalid1_r;
  assign bus.mem_rd         = mem_rd_r;
  assign bus.mem_wr         = mem_wr_r;
  assign bus.mem_addr       = addr_r;
  assign bus.mem_data_width = width_r;
  assign bus.mem_wr_data    = wdata_r;
  assign bus.busy           = busy_r;
  assign bus.owner          = owner_r;
  assign bus.err_stray      = err_stray_r;
`ifdef MEM_ARB_RD_TIMEOUT_EN
  assign bus.err_timeout    = err_timeout_r;
`else
  assign bus.err_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter.
// Stimulus pushes the expected ack (port + command on the memory port) and
// expected read returns (port + data) into queues; a negedge monitor pops and
// compares whenever the arbiter presents an ack or rvalid.

module tb_mem_arbiter;
  localparam int ADDR_W = 27;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(
    .ADDR_W(ADDR_W),
    .STARVE_LIMIT(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic              port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        width;
    logic [31:0]       wdata;
  } ack_exp_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } rv_exp_t;

  ack_exp_t exp_ack[$];
  rv_exp_t  exp_rv[$];
  ack_exp_t ea;
  rv_exp_t  er;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard side.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_rd || bus.mem_wr) chk("strobe_exclusive", 32'(bus.mem_rd & bus.mem_wr), 32'd0);
      if (bus.ack0 || bus.ack1) begin
        if (exp_ack.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ack: ack0=%0d ack1=%0d with none expected at %0t", bus.ack0, bus.ack1, $time);
        end else begin
          ea = exp_ack.pop_front();
          chk("ack_port", {30'd0, bus.ack1, bus.ack0}, ea.port ? 32'd2 : 32'd1);
          chk("ack_mem_rd", 32'(bus.mem_rd), 32'(!ea.we));
          chk("ack_mem_wr", 32'(bus.mem_wr), 32'(ea.we));
          chk("ack_mem_addr", 32'(bus.mem_addr), 32'(ea.addr));
          chk("ack_mem_width", 32'(bus.mem_data_width), 32'(ea.width));
          if (ea.we) chk("ack_mem_wdata", bus.mem_wr_data, ea.wdata);
        end
      end
      if (bus.rvalid0 || bus.rvalid1) begin
        if (exp_rv.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rvalid: rvalid0=%0d rvalid1=%0d with none expected at %0t", bus.rvalid0, bus.rvalid1, $time);
        end else begin
          er = exp_rv.pop_front();
          chk("rvalid_port", {30'd0, bus.rvalid1, bus.rvalid0}, er.port ? 32'd2 : 32'd1);
          chk("rdata", er.port ? bus.rdata1 : bus.rdata0, er.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for an ack (bounded), then steps past the acceptance edge.
  task automatic wait_ack(input string name, input int budget);
    int  n    = 0;
    bit  seen = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) seen = 1;
      n++;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s: no ack within %0d cycles", name, budget);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic on, input logic we,
                         input logic [ADDR_W-1:0] addr, input logic [1:0] width,
                         input logic [31:0] wdata);
    if (port == 0) begin
      bus.req0 = on; bus.we0 = we; bus.addr0 = addr; bus.width0 = width; bus.wdata0 = wdata;
    end else begin
      bus.req1 = on; bus.we1 = we; bus.addr1 = addr; bus.width1 = width; bus.wdata1 = wdata;
    end
  endtask

  task automatic push_ack(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [1:0] width, input logic [31:0] wdata);
    ack_exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.width = width; e.wdata = wdata;
    exp_ack.push_back(e);
  endtask

  task automatic push_rv(input logic port, input logic [31:0] data);
    rv_exp_t e;
    e.port = port; e.data = data;
    exp_rv.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    set_req(0, 0, 0, '0, 2'b00, '0);
    set_req(1, 0, 0, '0, 2'b00, '0);
    bus.mem_rd_ready = 0; bus.mem_wr_ready = 0;
    bus.mem_rd_data  = '0; bus.mem_rd_valid = 0;
    rst = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_mem_rd", 32'(bus.mem_rd), 0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_rdata0", bus.rdata0, 0);
    chk("rst_err_stray", 32'(bus.err_stray), 0);
    chk("rst_err_timeout", 32'(bus.err_timeout), 0);
    tick();
    rst = 0;

    // Port-0 read, memory ready immediately.
    set_req(0, 1, 0, 27'h000010, 2'b11, '0);
    bus.mem_rd_ready = 1;
    push_ack(0, 0, 27'h000010, 2'b11, '0);
    wait_ack("t1_ack", 4);
    set_req(0, 0, 0, 27'h000010, 2'b11, '0);
    bus.mem_rd_ready = 0;
    @(negedge clk);
    chk("t1_strobe_one_cycle", 32'(bus.mem_rd), 0);
    chk("t1_busy_wait_rd", 32'(bus.busy), 1);
    tick();
    bus.mem_rd_valid = 1; bus.mem_rd_data = 32'h12345678;
    push_rv(0, 32'h12345678);
    tick();
    bus.mem_rd_valid = 0;
    @(negedge clk);
    chk("t1_busy_after", 32'(bus.busy), 0);
    tick();
    @(negedge clk);
    chk("t1_rdata0_held", bus.rdata0, 32'h12345678);

    // Port-1 write held off by memory for 5 cycles.
    tick();
    set_req(1, 1, 1, 27'h000021, 2'b01, 32'h000000AB);
    push_ack(1, 1, 27'h000021, 2'b01, 32'h000000AB);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_mem_wr_held", 32'(bus.mem_wr), 1);
      chk("t2_no_early_ack", 32'(bus.ack1), 0);
      chk("t2_addr_stable", 32'(bus.mem_addr), 32'h21);
      chk("t2_wdata_stable", bus.mem_wr_data, 32'hAB);
      tick();
    end
    bus.mem_wr_ready = 1;
    wait_ack("t2_ack", 2);
    set_req(1, 0, 1, 27'h000021, 2'b01, 32'h000000AB);
    bus.mem_wr_ready = 0;
    @(negedge clk);
    chk("t2_mem_wr_drop", 32'(bus.mem_wr), 0);
    chk("t2_busy_after", 32'(bus.busy), 0);
    tick();

    // Starvation: both ports hold write requests continuously.
    begin
      int acks = 0;
      for (int i = 0; i < 10; i++) begin
        if (i == 4 || i == 9) push_ack(1, 1, 27'h000200, 2'b11, 32'h22222222);
        else                  push_ack(0, 1, 27'h000100, 2'b11, 32'h11111111);
      end
      bus.mem_wr_ready = 1;
      set_req(0, 1, 1, 27'h000100, 2'b11, 32'h11111111);
      set_req(1, 1, 1, 27'h000200, 2'b11, 32'h22222222);
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (bus.ack0 || bus.ack1) acks++;
        if (acks == 10) break;
      end
      chk("t3_ack_count", acks, 10);
      @(posedge clk); #1;
      set_req(0, 0, 1, 27'h000100, 2'b11, 32'h11111111);
      set_req(1, 0, 1, 27'h000200, 2'b11, 32'h22222222);
      bus.mem_wr_ready = 0;
      tick();
    end

    // Port-1 read outstanding while port 0 asks for a write.
    set_req(1, 1, 0, 27'h000300, 2'b10, '0);
    bus.mem_rd_ready = 1;
    push_ack(1, 0, 27'h000300, 2'b10, '0);
    wait_ack("t4_ack1", 4);
    set_req(1, 0, 0, 27'h000300, 2'b10, '0);
    bus.mem_rd_ready = 0;
    set_req(0, 1, 1, 27'h000400, 2'b11, 32'hCAFEF00D);
    bus.mem_wr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_no_strobe", 32'(bus.mem_rd | bus.mem_wr), 0);
      chk("t4_addr_held", 32'(bus.mem_addr), 32'h300);
      chk("t4_width_held", 32'(bus.mem_data_width), 32'd2);
      tick();
    end
    bus.mem_rd_valid = 1; bus.mem_rd_data = 32'h55AA1234;
    push_rv(1, 32'h55AA1234);
    push_ack(0, 1, 27'h000400, 2'b11, 32'hCAFEF00D);
    tick();
    bus.mem_rd_valid = 0;
    @(negedge clk);
    chk("t4_no_wr_in_rvalid_cycle", 32'(bus.mem_wr), 0);
    wait_ack("t4_ack0", 4);
    set_req(0, 0, 1, 27'h000400, 2'b11, 32'hCAFEF00D);
    bus.mem_wr_ready = 0;
    tick();

    // Stray read return in IDLE.
    bus.mem_rd_valid = 1; bus.mem_rd_data = 32'h00000099;
    tick();
    bus.mem_rd_valid = 0;
    @(negedge clk);
    chk("t5_err_stray", 32'(bus.err_stray), 1);
    chk("t5_rdata0_kept", bus.rdata0, 32'h12345678);
    chk("t5_rdata1_kept", bus.rdata1, 32'h55AA1234);
    tick();

    // Reset while a read waits for its return.
    set_req(0, 1, 0, 27'h000500, 2'b11, '0);
    bus.mem_rd_ready = 1;
    push_ack(0, 0, 27'h000500, 2'b11, '0);
    wait_ack("t6_ack", 4);
    set_req(0, 0, 0, 27'h000500, 2'b11, '0);
    bus.mem_rd_ready = 0;
    tick();
    rst = 1;
    bus.mem_rd_valid = 1; bus.mem_rd_data = 32'h00000077;
    tick();
    rst = 0;
    bus.mem_rd_valid = 0;
    @(negedge clk);
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_rvalid0", 32'(bus.rvalid0), 0);
    chk("t6_mem_addr", 32'(bus.mem_addr), 0);
    chk("t6_mem_width", 32'(bus.mem_data_width), 0);
    chk("t6_rdata0", bus.rdata0, 0);
    chk("t6_rdata1", bus.rdata1, 0);
    chk("t6_err_stray", 32'(bus.err_stray), 0);
    repeat (3) tick();

`ifdef MEM_ARB_RD_TIMEOUT_EN
    // Read that memory never answers: watchdog returns the marker word.
    begin
      int n    = 0;
      bit seen = 0;
      set_req(0, 1, 0, 27'h000600, 2'b11, '0);
      bus.mem_rd_ready = 1;
      push_ack(0, 0, 27'h000600, 2'b11, '0);
      push_rv(0, 32'hDEADBEEF);
      wait_ack("t7_ack", 4);
      set_req(0, 0, 0, 27'h000600, 2'b11, '0);
      bus.mem_rd_ready = 0;
      while (!seen && n < 40) begin
        @(negedge clk);
        n++;
        if (bus.rvalid0) seen = 1;
      end
      chk("t7_timeout_latency", n, 17);
      chk("t7_err_timeout", 32'(bus.err_timeout), 1);
      chk("t7_err_stray_before", 32'(bus.err_stray), 0);
      tick();
      bus.mem_rd_valid = 1; bus.mem_rd_data = 32'h0BADF00D;
      tick();
      bus.mem_rd_valid = 0;
      @(negedge clk);
      chk("t7_late_valid_stray", 32'(bus.err_stray), 1);
      tick();
    end
`else
    // Without the watchdog the arbiter waits for the return indefinitely.
    set_req(1, 1, 0, 27'h000700, 2'b11, '0);
    bus.mem_rd_ready = 1;
    push_ack(1, 0, 27'h000700, 2'b11, '0);
    wait_ack("t7_ack", 4);
    set_req(1, 0, 0, 27'h000700, 2'b11, '0);
    bus.mem_rd_ready = 0;
    repeat (40) tick();
    @(negedge clk);
    chk("t7_still_busy", 32'(bus.busy), 1);
    chk("t7_err_timeout", 32'(bus.err_timeout), 0);
    tick();
    bus.mem_rd_valid = 1; bus.mem_rd_data = 32'hA5A5A5A5;
    push_rv(1, 32'hA5A5A5A5);
    tick();
    bus.mem_rd_valid = 0;
    @(negedge clk);
    chk("t7_busy_after", 32'(bus.busy), 0);
    tick();
`endif

    chk("ack_queue_drained", exp_ack.size(), 0);
    chk("rvalid_queue_drained", exp_rv.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
